polaris_uart_tl: RTL and testbench
==================================

// Module: polaris_uart_tl
// PURPOSE
//  TileLink-UL (TL-UL) register responder: the bus-side end of the polaris_uart_ip FIFO/control interface.
//  Decodes 32-bit register accesses and drives the UART's tx_fifo_en/rx_fifo_de strobes and its baud/enable config.
//  Samples the FIFO status flags. One clock domain, shared with the UART core; one outstanding request.
// PARAMETERS
//  TL_SID_W    4       width of a_source/d_source
//  TL_AW       32      a_address width; only a_address[4:2] decoded, upper bits ignored (interconnect decodes)
//  RESET_BAUD  12'd434 clktobaudrate_o reset value
// PORTS
//  uart_clk_i          in   1         clock
//  uart_rst_i          in   1         synchronous reset, active-high
//  a_valid/a_ready     in/out 1       TL channel A handshake
//  a_opcode/a_size     in   3/4       0=PutFull,1=PutPartial,4=Get; a_size echoed
//  a_source            in   TL_SID_W  echoed on d_source
//  a_address           in   TL_AW     register address
//  a_mask/a_data       in   4/32      byte lanes, write data
//  d_valid/d_ready     out/in 1       TL channel D handshake
//  d_opcode/d_size     out  3/4       0=AccessAck,1=AccessAckData; size echo
//  d_source/d_denied   out  TL_SID_W/1
//  d_data              out  32        read data (0 for writes/denied)
//  tx_fifo_en_o        out  1         1-cycle push strobe to TX FIFO
//  tx_fifo_en_data_o   out  8         push byte
//  rx_fifo_de_o        out  1         1-cycle pop strobe to RX FIFO
//  rx_fifo_de_data_i   in   8         RX FIFO data, registered: valid the cycle after rx_fifo_de_o
//  tx_fifo_full_i, tx_fifo_empty_i, rx_fifo_full_i, rx_fifo_empty_i  in 1 each: FIFO flags
//  clktobaudrate_o     out  12        baud divisor; tx_en_o/rx_en_o out 1: UART enables
// BEHAVIOUR
//  Reset: a_ready=0 in the reset cycle, then 1; d_valid=0; strobes 0; clktobaudrate_o=RESET_BAUD; tx_en_o=rx_en_o=0.
//  FSM IDLE->(accept)->RESP, or IDLE->RXPOP->RESP for a popping RXDATA read; RESP->IDLE on d_valid&d_ready.
//  a_ready=1 only in IDLE; request accepted on a_valid&a_ready; d_valid first asserted 1 cycle later (2 for RXPOP).
//  D fields are registered and stay stable while d_valid&!d_ready; at most one strobe per request.
//  Map (a_address[4:2]):
//   0x00 TXDATA W: if mask[0]&!tx_fifo_full_i, push a_data[7:0] in acceptance cycle; if full, drop and d_denied=1. Read=0.
//   0x04 RXDATA R: !rx_fifo_empty_i -> rx_fifo_de_o in acceptance cycle; RXPOP captures byte; d_data={24'b0,byte}.
//        Empty -> no pop, d_data=32'h8000_0000, not denied. Write ignored, AccessAck.
//   0x08 STATUS RO: {28'b0, rx_empty, rx_full, tx_empty, tx_full}, sampled at acceptance.
//   0x0C CTRL RW: [11:0] baud, [16] tx_en, [17] rx_en; bytes written per a_mask; rest reads 0.
//   others: denied, d_data=0, no side effects.
//  Opcode not in {0,1,4}: d_denied=1, d_opcode=AccessAck, no side effects.
//  Get -> AccessAckData; Put* -> AccessAck. CTRL write takes effect the cycle after acceptance.
//  Reset mid-op (incl. RXPOP/RESP): pending response dropped, FSM->IDLE, no further strobes; captured byte lost.
// CONFIGURATION
//  POLARIS_UART_IRQ_EN defined: adds irq_o (out 1) and IE register 0x10 RW [0] rx_ne_ie, [1] tx_empty_ie (reset 0).
//   irq_o registered = (ie[0]&!rx_fifo_empty_i)|(ie[1]&tx_fifo_empty_i); reset 0; 1-cycle lag to flags.
//  Undefined: no irq_o port; 0x10 is unmapped (denied, d_data=0).
// TESTING
//  PutFull TXDATA a_data=0x41 mask 0001, not full -> tx_fifo_en_o 1 cycle, data 0x41; AccessAck denied=0.
//  TXDATA write with tx_fifo_full_i=1 -> no strobe, d_denied=1; Get 0x14 -> denied, d_data=0.
//  RX FIFO holds 0x5A; Get 0x04 -> one rx_fifo_de_o, d_valid 2 cycles after accept, d_data=0x5A. Empty -> 0x8000_0000, no pop.
//  PutFull CTRL 0x0003_01B2 -> baud=0x1B2, tx_en=rx_en=1; PutPartial mask 0001 data 0xFF -> baud=0x1FF, enables kept.
//  d_ready low 5 cycles -> d_valid/d_data held, a_ready=0, no extra strobes; reset in RXPOP -> d_valid never rises.
//  IRQ_EN: IE=1, RX FIFO non-empty -> irq_o=1 next cycle; pop to empty -> irq_o=0; build without macro -> 0x10 denied.

Source files
------------

// File: rtl/polaris_uart_tl.sv
// TL-UL register responder for the polaris_uart_ip FIFO/control interface.
// Optional interrupt support is compiled in with `define POLARIS_UART_IRQ_EN (adds irq_o and IE @0x10).
module polaris_uart_tl #(
  parameter int unsigned TL_SID_W   = 4,
  parameter int unsigned TL_AW      = 32,
  parameter logic [11:0] RESET_BAUD = 12'd434
) (
  input  logic                uart_clk_i,
  input  logic                uart_rst_i,
  // TL-UL channel A
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [3:0]          a_size,
  input  logic [TL_SID_W-1:0] a_source,
  input  logic [TL_AW-1:0]    a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  // TL-UL channel D
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [3:0]          d_size,
  output logic [TL_SID_W-1:0] d_source,
  output logic                d_denied,
  output logic [31:0]         d_data,
  // UART FIFO side
  output logic                tx_fifo_en_o,
  output logic [7:0]          tx_fifo_en_data_o,
  output logic                rx_fifo_de_o,
  input  logic [7:0]          rx_fifo_de_data_i,
  input  logic                tx_fifo_full_i,
  input  logic                tx_fifo_empty_i,
  input  logic                rx_fifo_full_i,
  input  logic                rx_fifo_empty_i,
  // UART configuration
  output logic [11:0]         clktobaudrate_o,
  output logic                tx_en_o,
  output logic                rx_en_o
`ifdef POLARIS_UART_IRQ_EN
  ,
  output logic                irq_o
`endif
);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] D_ACK          = 3'd0;
  localparam logic [2:0] D_ACK_DATA     = 3'd1;

  typedef enum logic [2:0] {
    REG_TXDATA = 3'd0,
    REG_RXDATA = 3'd1,
    REG_STATUS = 3'd2,
    REG_CTRL   = 3'd3,
    REG_IE     = 3'd4
  } reg_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RXPOP,
    ST_RESP
  } state_e;

  state_e                state_q;
  logic                  a_ready_q;
  logic                  d_valid_q;
  logic [2:0]            d_opcode_q;
  logic [3:0]            d_size_q;
  logic [TL_SID_W-1:0]   d_source_q;
  logic                  d_denied_q;
  logic [31:0]           d_data_q;
  logic [11:0]           baud_q;
  logic                  tx_en_q;
  logic                  rx_en_q;

  reg_idx_e              reg_idx;
  logic                  accept;
  logic                  is_get;
  logic                  is_put;
  logic                  rsp_denied;
  logic [31:0]           rsp_data;
  logic [2:0]            rsp_opcode;
  logic                  push;
  logic                  pop;
  logic                  ctrl_wr;
  logic                  ie_wr;

`ifdef POLARIS_UART_IRQ_EN
  logic [1:0]            ie_q;
  logic                  irq_q;
`endif

  assign reg_idx = reg_idx_e'(a_address[4:2]);
  // Upper address bits belong to the interconnect decode; only lanes that map to fields are used.
  logic unused_bits;
  assign unused_bits = ^{a_address[TL_AW-1:5], a_address[1:0], a_data[31:18], a_data[15:12], a_mask[3]};

  // Request decode; strobes fire combinationally in the acceptance cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred on untaken paths.
    accept     = a_valid & a_ready_q & ~uart_rst_i;
    is_get     = (a_opcode == OP_GET);
    is_put     = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PARTIAL);
    rsp_opcode = is_get ? D_ACK_DATA : D_ACK;
    rsp_denied = 1'b0;
    rsp_data   = 32'h0;
    push       = 1'b0;
    pop        = 1'b0;
    ctrl_wr    = 1'b0;
    ie_wr      = 1'b0;
    if (!(is_get | is_put)) begin
      rsp_denied = 1'b1;
    end else begin
      case (reg_idx)
        REG_TXDATA: begin
          if (is_put && a_mask[0]) begin
            if (tx_fifo_full_i) rsp_denied = 1'b1;
            else                push       = 1'b1;
          end
        end
        REG_RXDATA: begin
          if (is_get) begin
            if (!rx_fifo_empty_i) pop      = 1'b1;
            else                  rsp_data = 32'h8000_0000;
          end
        end
        REG_STATUS: begin
          if (is_get) rsp_data = {28'h0, rx_fifo_empty_i, rx_fifo_full_i, tx_fifo_empty_i, tx_fifo_full_i};
        end
        REG_CTRL: begin
          if (is_get) rsp_data = {14'h0, rx_en_q, tx_en_q, 4'h0, baud_q};
          else        ctrl_wr  = 1'b1;
        end
`ifdef POLARIS_UART_IRQ_EN
        REG_IE: begin
          if (is_get) rsp_data = {30'h0, ie_q};
          else        ie_wr    = 1'b1;
        end
`endif
        default: rsp_denied = 1'b1;
      endcase
    end
  end

  assign tx_fifo_en_o      = accept & push;
  assign tx_fifo_en_data_o = a_data[7:0];
  assign rx_fifo_de_o      = accept & pop;

  always_ff @(posedge uart_clk_i) begin
    if (uart_rst_i) begin
      state_q    <= ST_IDLE;
      a_ready_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= D_ACK;
      d_size_q   <= 4'h0;
      d_source_q <= '0;
      d_denied_q <= 1'b0;
      d_data_q   <= 32'h0;
      baud_q     <= RESET_BAUD;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
`ifdef POLARIS_UART_IRQ_EN
      ie_q       <= 2'b00;
      irq_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values, independent of statement order.
      case (state_q)
        ST_IDLE: begin
          a_ready_q <= 1'b1;
          if (accept) begin
            a_ready_q  <= 1'b0;
            d_opcode_q <= rsp_opcode;
            d_size_q   <= a_size;
            d_source_q <= a_source;
            d_denied_q <= rsp_denied;
            d_data_q   <= rsp_data;
            if (pop) begin
              state_q <= ST_RXPOP;
            end else begin
              state_q   <= ST_RESP;
              d_valid_q <= 1'b1;
            end
            if (ctrl_wr) begin
              if (a_mask[0]) baud_q[7:0]  <= a_data[7:0];
              if (a_mask[1]) baud_q[11:8] <= a_data[11:8];
              if (a_mask[2]) begin
                tx_en_q <= a_data[16];
                rx_en_q <= a_data[17];
              end
            end
`ifdef POLARIS_UART_IRQ_EN
            if (ie_wr && a_mask[0]) ie_q <= a_data[1:0];
`endif
          end
        end
        ST_RXPOP: begin
          // FIFO read data is registered, so the popped byte is valid only now.
          d_data_q  <= {24'h0, rx_fifo_de_data_i};
          d_valid_q <= 1'b1;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (d_ready) begin
            d_valid_q <= 1'b0;
            a_ready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef POLARIS_UART_IRQ_EN
      irq_q <= (ie_q[0] & ~rx_fifo_empty_i) | (ie_q[1] & tx_fifo_empty_i);
`endif
    end
  end

  assign a_ready         = a_ready_q;
  assign d_valid         = d_valid_q;
  assign d_opcode        = d_opcode_q;
  assign d_size          = d_size_q;
  assign d_source        = d_source_q;
  assign d_denied        = d_denied_q;
  assign d_data          = d_data_q;
  assign clktobaudrate_o = baud_q;
  assign tx_en_o         = tx_en_q;
  assign rx_en_o         = rx_en_q;
`ifdef POLARIS_UART_IRQ_EN
  assign irq_o           = irq_q;
`endif

endmodule

// File: tb/tb_polaris_uart_tl.sv
// Self-checking bench for polaris_uart_tl: table of directed TL-UL requests plus hand-written
// sequences for back-pressure, CTRL timing, reset during a pop and (when built with it) the IRQ option.
module tb_polaris_uart_tl;

  logic        clk;
  logic        rst;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode;
  logic [3:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [3:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        tx_en_s, rx_de_s;
  logic [7:0]  tx_data_s, rx_byte;
  logic [3:0]  flags; // {rx_empty, rx_full, tx_empty, tx_full}
  logic [11:0] baud;
  logic        tx_en, rx_en;
`ifdef POLARIS_UART_IRQ_EN
  logic        irq;
`endif

  polaris_uart_tl dut (
`ifdef POLARIS_UART_IRQ_EN
    .irq_o             (irq),
`endif
    .uart_clk_i        (clk),
    .uart_rst_i        (rst),
    .a_valid           (a_valid),
    .a_ready           (a_ready),
    .a_opcode          (a_opcode),
    .a_size            (a_size),
    .a_source          (a_source),
    .a_address         (a_address),
    .a_mask            (a_mask),
    .a_data            (a_data),
    .d_valid           (d_valid),
    .d_ready           (d_ready),
    .d_opcode          (d_opcode),
    .d_size            (d_size),
    .d_source          (d_source),
    .d_denied          (d_denied),
    .d_data            (d_data),
    .tx_fifo_en_o      (tx_en_s),
    .tx_fifo_en_data_o (tx_data_s),
    .rx_fifo_de_o      (rx_de_s),
    .rx_fifo_de_data_i (rx_byte),
    .tx_fifo_full_i    (flags[0]),
    .tx_fifo_empty_i   (flags[1]),
    .rx_fifo_full_i    (flags[2]),
    .rx_fifo_empty_i   (flags[3]),
    .clktobaudrate_o   (baud),
    .tx_en_o           (tx_en),
    .rx_en_o           (rx_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [3:0]  flags;
    logic [7:0]  rx_byte;
    logic        exp_push;
    logic        exp_pop;
    logic [2:0]  exp_dop;
    logic        exp_denied;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [2:0] op, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input logic [3:0] fl,
                         input logic [7:0] rb, input logic ep, input logic epop,
                         input logic [2:0] edop, input logic eden, input logic [31:0] edata);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.mask = mask; v.data = data; v.flags = fl;
    v.rx_byte = rb; v.exp_push = ep; v.exp_pop = epop; v.exp_dop = edop;
    v.exp_denied = eden; v.exp_data = edata;
    vecs.push_back(v);
  endtask

  // Results captured by run_req
  logic        got_ready, got_push, got_pop, got_dop_den;
  logic [7:0]  got_push_data;
  int          got_lat, got_extra;
  logic [2:0]  got_dop;
  logic [3:0]  got_size, got_src;
  logic        got_denied;
  logic [31:0] got_data;

  // Issue one request (call #1 after a posedge); returns after the D handshake edge + #1.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [3:0] src, input logic [3:0] size);
    int n;
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask; a_data = data;
    a_source = src; a_size = size;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    got_ready     = a_ready;
    got_push      = tx_en_s;
    got_push_data = tx_data_s;
    got_pop       = rx_de_s;
    @(posedge clk); #1;
    a_valid = 1'b0;
    got_lat = 0; got_extra = 0;
    do begin
      @(negedge clk);
      got_lat++;
      if (tx_en_s || rx_de_s) got_extra++;
    end while (!d_valid && got_lat < 20);
    got_dop = d_opcode; got_size = d_size; got_src = d_source;
    got_denied = d_denied; got_data = d_data;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_dv, cnt_st, cnt_rdy;
    a_valid = 0; a_opcode = 3'd4; a_size = 0; a_source = 0; a_address = 0; a_mask = 0; a_data = 0;
    d_ready = 1; rx_byte = 0; flags = 4'b1010; rst = 1;

    // PutFull=0 PutPartial=1 Get=4; AccessAck=0 AccessAckData=1
    add_vec("tx_push",   3'd0, 32'h00, 4'h1, 32'h41,        4'b1010, 8'h00, 1, 0, 3'd0, 0, 32'h0);
    add_vec("tx_full",   3'd0, 32'h00, 4'h1, 32'h99,        4'b1001, 8'h00, 0, 0, 3'd0, 1, 32'h0);
    add_vec("tx_nolane", 3'd1, 32'h00, 4'h2, 32'h1234,      4'b1010, 8'h00, 0, 0, 3'd0, 0, 32'h0);
    add_vec("tx_get",    3'd4, 32'h00, 4'hF, 32'h0,         4'b1010, 8'h00, 0, 0, 3'd1, 0, 32'h0);
    add_vec("rx_pop",    3'd4, 32'h04, 4'hF, 32'h0,         4'b0010, 8'h5A, 0, 1, 3'd1, 0, 32'h5A);
    add_vec("rx_empty",  3'd4, 32'h04, 4'hF, 32'h0,         4'b1010, 8'h33, 0, 0, 3'd1, 0, 32'h8000_0000);
    add_vec("rx_write",  3'd0, 32'h04, 4'hF, 32'h77,        4'b0010, 8'h77, 0, 0, 3'd0, 0, 32'h0);
    add_vec("status_a",  3'd4, 32'h08, 4'hF, 32'h0,         4'b0101, 8'h00, 0, 0, 3'd1, 0, 32'h5);
    add_vec("status_hi", 3'd4, 32'hFFFF_FF08, 4'hF, 32'h0,  4'b1010, 8'h00, 0, 0, 3'd1, 0, 32'hA);
    add_vec("status_wr", 3'd0, 32'h08, 4'hF, 32'hFFFF_FFFF, 4'b1010, 8'h00, 0, 0, 3'd0, 0, 32'h0);
    add_vec("ctrl_full", 3'd0, 32'h0C, 4'hF, 32'h0003_01B2, 4'b1010, 8'h00, 0, 0, 3'd0, 0, 32'h0);
    add_vec("ctrl_rd1",  3'd4, 32'h0C, 4'hF, 32'h0,         4'b1010, 8'h00, 0, 0, 3'd1, 0, 32'h0003_01B2);
    add_vec("ctrl_part", 3'd1, 32'h0C, 4'h1, 32'hFF,        4'b1010, 8'h00, 0, 0, 3'd0, 0, 32'h0);
    add_vec("ctrl_rd2",  3'd4, 32'h0C, 4'hF, 32'h0,         4'b1010, 8'h00, 0, 0, 3'd1, 0, 32'h0003_01FF);
    add_vec("ctrl_hi",   3'd1, 32'h0C, 4'h6, 32'h0001_F300, 4'b1010, 8'h00, 0, 0, 3'd0, 0, 32'h0);
    add_vec("ctrl_rd3",  3'd4, 32'h0C, 4'hF, 32'h0,         4'b1010, 8'h00, 0, 0, 3'd1, 0, 32'h0001_03FF);
    add_vec("bad_op_tx", 3'd3, 32'h00, 4'h1, 32'h55,        4'b1010, 8'h00, 0, 0, 3'd0, 1, 32'h0);
    add_vec("bad_op_rx", 3'd5, 32'h04, 4'hF, 32'h0,         4'b0010, 8'h21, 0, 0, 3'd0, 1, 32'h0);
    add_vec("unmap_14",  3'd4, 32'h14, 4'hF, 32'h0,         4'b1010, 8'h00, 0, 0, 3'd1, 1, 32'h0);
    add_vec("unmap_1c",  3'd0, 32'h1C, 4'hF, 32'h1,         4'b1010, 8'h00, 0, 0, 3'd0, 1, 32'h0);
`ifdef POLARIS_UART_IRQ_EN
    add_vec("addr_10",   3'd4, 32'h10, 4'hF, 32'h0,         4'b1010, 8'h00, 0, 0, 3'd1, 0, 32'h0);
`else
    add_vec("addr_10",   3'd4, 32'h10, 4'hF, 32'h0,         4'b1010, 8'h00, 0, 0, 3'd1, 1, 32'h0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", {31'h0, a_ready}, 32'h0);
    check("rst_d_valid", {31'h0, d_valid}, 32'h0);
    check("rst_baud",    {20'h0, baud}, 32'd434);
    check("rst_enables", {30'h0, tx_en, rx_en}, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_a_ready", {31'h0, a_ready}, 32'h1);
    @(posedge clk); #1;

    // Table-driven requests
    foreach (vecs[i]) begin
      flags   = vecs[i].flags;
      rx_byte = vecs[i].rx_byte;
      run_req(vecs[i].op, vecs[i].addr, vecs[i].mask, vecs[i].data, 4'(i), 4'(i % 3));
      check({vecs[i].name, "_ready"},  {31'h0, got_ready}, 32'h1);
      check({vecs[i].name, "_push"},   {31'h0, got_push}, {31'h0, vecs[i].exp_push});
      if (vecs[i].exp_push) check({vecs[i].name, "_pdata"}, {24'h0, got_push_data}, {24'h0, vecs[i].data[7:0]});
      check({vecs[i].name, "_pop"},    {31'h0, got_pop}, {31'h0, vecs[i].exp_pop});
      check({vecs[i].name, "_lat"},    got_lat, vecs[i].exp_pop ? 32'd2 : 32'd1);
      check({vecs[i].name, "_extra"},  got_extra, 32'd0);
      check({vecs[i].name, "_dop"},    {29'h0, got_dop}, {29'h0, vecs[i].exp_dop});
      check({vecs[i].name, "_denied"}, {31'h0, got_denied}, {31'h0, vecs[i].exp_denied});
      check({vecs[i].name, "_data"},   got_data, vecs[i].exp_data);
      check({vecs[i].name, "_src"},    {28'h0, got_src}, 32'(i % 16));
      check({vecs[i].name, "_size"},   {28'h0, got_size}, 32'(i % 3));
    end
    check("cfg_baud",  {20'h0, baud}, 32'h3FF);
    check("cfg_tx_en", {31'h0, tx_en}, 32'h1);
    check("cfg_rx_en", {31'h0, rx_en}, 32'h0);

    // CTRL write becomes visible the cycle after acceptance
    flags = 4'b1010;
    a_valid = 1; a_opcode = 3'd0; a_address = 32'h0C; a_mask = 4'hF; a_data = 32'h0002_0123;
    @(negedge clk);
    check("ctrl_t0_ready", {31'h0, a_ready}, 32'h1);
    check("ctrl_t0_baud",  {20'h0, baud}, 32'h3FF);
    @(posedge clk); #1;
    a_valid = 0;
    @(negedge clk);
    check("ctrl_t1_baud", {20'h0, baud}, 32'h123);
    check("ctrl_t1_en",   {30'h0, tx_en, rx_en}, 32'h1);
    @(posedge clk); #1;

    // Back-pressure: response held, no new acceptance, no strobes
    flags = 4'b0101; d_ready = 0;
    a_valid = 1; a_opcode = 3'd4; a_address = 32'h08; a_mask = 4'hF; a_source = 4'h9; a_size = 4'h2;
    @(negedge clk);
    check("stall_accept", {31'h0, a_ready}, 32'h1);
    @(posedge clk); #1;
    flags = 4'b1010; a_opcode = 3'd0; a_address = 32'h00; a_mask = 4'h1; a_data = 32'h33;
    cnt_dv = 0; cnt_st = 0; cnt_rdy = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (d_valid) cnt_dv++;
      if (tx_en_s || rx_de_s) cnt_st++;
      if (a_ready) cnt_rdy++;
      check("stall_data", d_data, 32'h5);
    end
    check("stall_dvalid",  cnt_dv, 32'd5);
    check("stall_strobes", cnt_st, 32'd0);
    check("stall_aready",  cnt_rdy, 32'd0);
    check("stall_src",     {28'h0, d_source}, 32'h9);
    @(posedge clk); #1;
    a_valid = 0; d_ready = 1;
    @(negedge clk);
    check("stall_release_dv", {31'h0, d_valid}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_done_dv",    {31'h0, d_valid}, 32'h0);
    check("stall_done_ready", {31'h0, a_ready}, 32'h1);
    @(posedge clk); #1;

    // Reset while in RXPOP: response dropped, configuration back to reset values
    flags = 4'b0010; rx_byte = 8'h66;
    a_valid = 1; a_opcode = 3'd4; a_address = 32'h04; a_mask = 4'hF;
    @(negedge clk);
    check("rstpop_pop", {31'h0, rx_de_s}, 32'h1);
    @(posedge clk); #1;
    a_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rstpop_baud",  {20'h0, baud}, 32'd434);
    check("rstpop_en",    {30'h0, tx_en, rx_en}, 32'h0);
    check("rstpop_ready", {31'h0, a_ready}, 32'h0);
    cnt_dv = 0; cnt_st = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_valid) cnt_dv++;
      if (tx_en_s || rx_de_s) cnt_st++;
    end
    check("rstpop_no_dvalid", cnt_dv, 32'd0);
    check("rstpop_no_strobe", cnt_st, 32'd0);
    check("rstpop_ready_back", {31'h0, a_ready}, 32'h1);
    @(posedge clk); #1;

`ifdef POLARIS_UART_IRQ_EN
    // rx_ne interrupt follows the RX flag with one cycle of lag
    flags = 4'b1000;
    run_req(3'd0, 32'h10, 4'h1, 32'h1, 4'h0, 4'h2);
    check("ie_wr_denied", {31'h0, got_denied}, 32'h0);
    flags = 4'b0000;
    @(negedge clk);
    check("irq_lag", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_rx_ne", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    rx_byte = 8'h12;
    run_req(3'd4, 32'h04, 4'hF, 32'h0, 4'h0, 4'h2);
    check("irq_pop_data", got_data, 32'h12);
    flags = 4'b1000;
    @(posedge clk); #1;
    @(negedge clk);
    check("irq_rx_empty", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    run_req(3'd0, 32'h10, 4'h1, 32'h2, 4'h0, 4'h2);
    flags = 4'b1010;
    @(posedge clk); #1;
    @(negedge clk);
    check("irq_tx_empty", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
